jk_reg_bank: RTL and testbench
==============================

// Module: jk_reg_bank
// PURPOSE
//  WIDTH-bit bank of edge-triggered flip-flops, each bit built from a D flop plus next-state logic.
//  A runtime MODE selects D, JK, T or SR behaviour for the whole bank.
//  Detects illegal SR inputs and keeps a sticky error flag.
//  Reports how many bits changed on each edge and accumulates that count in a saturating counter.
//  Next-generation replacement for single-bit JK-from-D flops in the misc/flip-flop library.
// PARAMETERS
//  WIDTH    8      number of flip-flop bits (>=1)
//  RST_VAL  0      WIDTH-bit value loaded into q on reset
//  ACC_W    16     width of the saturating change accumulator
//  CNT_W    (local) $clog2(WIDTH+1), width of chg_cnt
// PORTS
//  clk      in   1      rising-edge clock, single clock domain
//  rst      in   1      synchronous reset, active-high
//  en       in   1      update enable; 0 = whole bank holds
//  mode     in   2      00=D  01=JK  10=T  11=SR
//  j        in   WIDTH  D in D mode; J in JK; T in T mode; S in SR
//  k        in   WIDTH  K in JK mode; R in SR mode; ignored in D and T modes
//  clr_err  in   1      clears sticky err
//  q        out  WIDTH  registered state
//  qb       out  WIDTH  ~q (combinational from q, never registered separately)
//  err      out  1      sticky: an SR 11 input was sampled
//  chg_cnt  out  CNT_W  number of q bits that changed on the last edge
//  chg_acc  out  ACC_W  saturating running total of chg_cnt
// BEHAVIOUR
//  - Reset: all state updates on the rising clk edge only; no async paths.
//      - rst=1 at an edge: q<=RST_VAL, err<=0, chg_cnt<=0, chg_acc<=0.
//      - rst overrides en, mode and clr_err.
//  - en=0: q holds; chg_cnt<=0; chg_acc holds; err holds (subject to clr_err).
//  - en=1, per bit i, nq[i] is:
//      - D:  nq = j
//      - JK: jk 00 hold, 10 set, 01 clear, 11 toggle
//      - T:  nq = q ^ j
//      - SR: 00 hold, 10 set, 01 clear, 11 hold that bit and raise error
//  - Latency: q updates 1 edge after inputs are sampled. chg_cnt and chg_acc update on the same
//    edge and describe that same transition: chg_cnt <= popcount(q ^ nq).
//  - chg_acc <= min(chg_acc + chg_cnt_next, 2^ACC_W-1).
//      - Computed in ACC_W+1 bits, then clamped.
//      - Once saturated it stays at max until rst.
//  - err:
//      - Set on any edge with en=1, mode=11 and any bit having j&k=1.
//      - Cleared by clr_err=1 at an edge.
//      - A set and a clear on the same edge leave err=1 (set wins).
//  - mode may change every cycle; each edge uses the mode sampled at that edge, with no pipeline.
//  - Reset mid-sequence discards any pending change count; accumulation restarts from 0.
// TESTING  (WIDTH=8, RST_VAL=8'h00, ACC_W=4)
//  1. rst=1 for 2 edges, then en=1, mode=00, j=8'hA5
//     -> after 1 edge: q=A5, qb=5A, chg_cnt=4, chg_acc=4, err=0.
//  2. mode=01 from q=A5; j=8'h0F, k=8'hF0 -> q=0F;
//     then j=k=8'hFF -> q=F0, chg_cnt=8;
//     then j=k=0 -> q=F0, chg_cnt=0.
//  3. mode=10, j=8'h01 for 3 edges from q=00 -> q=01,00,01; chg_cnt=1 each edge.
//     en=0 for 2 edges -> q=01 held, chg_cnt=0.
//  4. mode=11 from q=00, j=8'h03, k=8'h06
//     -> q=01 (bit1 held), err=1.
//     Then j=k=0 -> err stays 1.
//     clr_err=1 together with j=k=8'h01 -> err still 1.
//     clr_err=1 alone -> err=0.
//  5. Saturation: D mode, alternate j=FF and j=00 from q=00 -> chg_acc=8, then 15, then stays 15.
//     rst=1 -> chg_acc=0, q=00.
//  6. Reset mid-operation: en=1, JK toggle, assert rst on the same edge
//     -> q=RST_VAL, chg_cnt=0, err=0.
//     Resumes normally on the next edge after rst=0.

Source files
------------

// File: rtl/jk_reg_bank.sv
// WIDTH-bit flip-flop bank with runtime-selectable D/JK/T/SR behaviour,
// sticky illegal-SR flag and a per-edge change count with saturating total.
module jk_reg_bank #(
  parameter int              WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int              ACC_W   = 16,
  localparam int             CNT_W   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             err,
  output logic [CNT_W-1:0] chg_cnt,
  output logic [ACC_W-1:0] chg_acc
);

  localparam logic [1:0] MODE_D  = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_T  = 2'b10;
  localparam logic [1:0] MODE_SR = 2'b11;

  // Sum is wide enough for either operand plus a carry, so the clamp is exact.
  localparam int SUM_W = ((CNT_W > ACC_W) ? CNT_W : ACC_W) + 1;
  localparam logic [SUM_W-1:0] ACC_MAX = {{(SUM_W - ACC_W){1'b0}}, {ACC_W{1'b1}}};

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] nq;
  logic             err_reg;
  logic             err_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] acc_next;
  logic [SUM_W-1:0] acc_sum;
  logic             sr_illegal;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      always_comb begin
        nq[gi] = q_reg[gi];
        case (mode)
          MODE_D:  nq[gi] = j[gi];
          MODE_JK: nq[gi] = (j[gi] & ~q_reg[gi]) | (~k[gi] & q_reg[gi]);
          MODE_T:  nq[gi] = q_reg[gi] ^ j[gi];
          MODE_SR: begin
            // S=R=1 is illegal: the bit holds and err is raised bank-wide
            if (j[gi] && !k[gi])
              nq[gi] = 1'b1;
            else if (!j[gi] && k[gi])
              nq[gi] = 1'b0;
          end
          default: nq[gi] = q_reg[gi];
        endcase
      end
    end
  endgenerate

  assign q_next     = en ? nq : q_reg;
  assign sr_illegal = en && (mode == MODE_SR) && (|(j & k));
  assign err_next   = sr_illegal ? 1'b1 : (clr_err ? 1'b0 : err_reg);

  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < WIDTH; i++)
      cnt_next = cnt_next + CNT_W'(q_reg[i] ^ q_next[i]);
  end

  always_comb begin
    acc_sum  = {{(SUM_W - ACC_W){1'b0}}, acc_reg} + {{(SUM_W - CNT_W){1'b0}}, cnt_next};
    acc_next = (acc_sum > ACC_MAX) ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg   <= RST_VAL;
      err_reg <= 1'b0;
      cnt_reg <= '0;
      acc_reg <= '0;
    end else begin
      q_reg   <= q_next;
      err_reg <= err_next;
      cnt_reg <= cnt_next;
      acc_reg <= acc_next;
    end
  end

  assign q       = q_reg;
  assign qb      = ~q_reg;
  assign err     = err_reg;
  assign chg_cnt = cnt_reg;
  assign chg_acc = acc_reg;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed bench for jk_reg_bank with WIDTH=8, RST_VAL=0, ACC_W=4.
module tb_jk_reg_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [7:0] j;
  logic [7:0] k;
  logic       clr_err;
  logic [7:0] q;
  logic [7:0] qb;
  logic       err;
  logic [3:0] chg_cnt;
  logic [3:0] chg_acc;

  int checks = 0;
  int fails  = 0;

  jk_reg_bank #(.WIDTH(8), .RST_VAL(8'h00), .ACC_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k),
    .clr_err(clr_err), .q(q), .qb(qb), .err(err),
    .chg_cnt(chg_cnt), .chg_acc(chg_acc)
  );

  always #5 clk = ~clk;

  // Drive one set of inputs, take one rising edge, settle 1 time unit past it.
  task automatic step(input logic r, input logic e, input logic [1:0] m,
                      input logic [7:0] jv, input logic [7:0] kv, input logic c);
    rst = r; en = e; mode = m; j = jv; k = kv; clr_err = c;
    @(posedge clk);
    #1;
    $display("txn rst=%0b en=%0b mode=%0d j=%h k=%h clr=%0b -> q=%h qb=%h err=%0b cnt=%0d acc=%0d",
             r, e, m, jv, kv, c, q, qb, err, chg_cnt, chg_acc);
  endtask

  task automatic test_reset;
    step(1, 1, 2'b01, 8'hFF, 8'hFF, 0);
    step(1, 1, 2'b01, 8'hFF, 8'hFF, 0);
    checks++; if (q !== 8'h00) begin fails++; $display("FAIL reset_q got %h want 00", q); end
    checks++; if (qb !== 8'hFF) begin fails++; $display("FAIL reset_qb got %h want FF", qb); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (chg_cnt !== 4'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", chg_cnt); end
    checks++; if (chg_acc !== 4'd0) begin fails++; $display("FAIL reset_acc got %0d want 0", chg_acc); end
  endtask

  task automatic test_d_mode;
    step(0, 1, 2'b00, 8'hA5, 8'h00, 0);
    checks++; if (q !== 8'hA5) begin fails++; $display("FAIL d_q got %h want A5", q); end
    checks++; if (qb !== 8'h5A) begin fails++; $display("FAIL d_qb got %h want 5A", qb); end
    checks++; if (chg_cnt !== 4'd4) begin fails++; $display("FAIL d_cnt got %0d want 4", chg_cnt); end
    checks++; if (chg_acc !== 4'd4) begin fails++; $display("FAIL d_acc got %0d want 4", chg_acc); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL d_err got %b want 0", err); end
  endtask

  // Continues from q=A5, acc=4.
  task automatic test_jk_mode;
    step(0, 1, 2'b01, 8'h0F, 8'hF0, 0);
    checks++; if (q !== 8'h0F) begin fails++; $display("FAIL jk_setclr_q got %h want 0F", q); end
    checks++; if (chg_cnt !== 4'd4) begin fails++; $display("FAIL jk_setclr_cnt got %0d want 4", chg_cnt); end
    checks++; if (chg_acc !== 4'd8) begin fails++; $display("FAIL jk_setclr_acc got %0d want 8", chg_acc); end
    step(0, 1, 2'b01, 8'hFF, 8'hFF, 0);
    checks++; if (q !== 8'hF0) begin fails++; $display("FAIL jk_toggle_q got %h want F0", q); end
    checks++; if (chg_cnt !== 4'd8) begin fails++; $display("FAIL jk_toggle_cnt got %0d want 8", chg_cnt); end
    checks++; if (chg_acc !== 4'd15) begin fails++; $display("FAIL jk_toggle_acc got %0d want 15", chg_acc); end
    step(0, 1, 2'b01, 8'h00, 8'h00, 0);
    checks++; if (q !== 8'hF0) begin fails++; $display("FAIL jk_hold_q got %h want F0", q); end
    checks++; if (chg_cnt !== 4'd0) begin fails++; $display("FAIL jk_hold_cnt got %0d want 0", chg_cnt); end
  endtask

  task automatic test_t_mode;
    logic [7:0] exp_q [3];
    exp_q[0] = 8'h01; exp_q[1] = 8'h00; exp_q[2] = 8'h01;
    step(1, 0, 2'b00, 8'h00, 8'h00, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 2'b10, 8'h01, 8'h00, 0);
      checks++; if (q !== exp_q[i]) begin fails++; $display("FAIL t_q[%0d] got %h want %h", i, q, exp_q[i]); end
      checks++; if (chg_cnt !== 4'd1) begin fails++; $display("FAIL t_cnt[%0d] got %0d want 1", i, chg_cnt); end
      checks++; if (chg_acc !== 4'(i + 1)) begin fails++; $display("FAIL t_acc[%0d] got %0d want %0d", i, chg_acc, i + 1); end
    end
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 2'b10, 8'hFF, 8'hFF, 0);
      checks++; if (q !== 8'h01) begin fails++; $display("FAIL en0_q[%0d] got %h want 01", i, q); end
      checks++; if (chg_cnt !== 4'd0) begin fails++; $display("FAIL en0_cnt[%0d] got %0d want 0", i, chg_cnt); end
      checks++; if (chg_acc !== 4'd3) begin fails++; $display("FAIL en0_acc[%0d] got %0d want 3", i, chg_acc); end
    end
  endtask

  task automatic test_sr_mode;
    step(1, 0, 2'b00, 8'h00, 8'h00, 0);
    step(0, 1, 2'b11, 8'h03, 8'h06, 0);
    checks++; if (q !== 8'h01) begin fails++; $display("FAIL sr_q got %h want 01", q); end
    checks++; if (err !== 1'b1) begin fails++; $display("FAIL sr_err got %b want 1", err); end
    checks++; if (chg_cnt !== 4'd1) begin fails++; $display("FAIL sr_cnt got %0d want 1", chg_cnt); end
    step(0, 1, 2'b11, 8'h00, 8'h00, 0);
    checks++; if (err !== 1'b1) begin fails++; $display("FAIL sr_sticky got %b want 1", err); end
    checks++; if (q !== 8'h01) begin fails++; $display("FAIL sr_hold_q got %h want 01", q); end
    step(0, 1, 2'b11, 8'h01, 8'h01, 1);
    checks++; if (err !== 1'b1) begin fails++; $display("FAIL sr_setwins got %b want 1", err); end
    checks++; if (q !== 8'h01) begin fails++; $display("FAIL sr_illegal_hold_q got %h want 01", q); end
    step(0, 1, 2'b11, 8'h00, 8'h00, 1);
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL sr_clear got %b want 0", err); end
  endtask

  task automatic test_saturation;
    logic [7:0] jv [4];
    logic [3:0] exp_acc [4];
    jv[0] = 8'hFF; jv[1] = 8'h00; jv[2] = 8'hFF; jv[3] = 8'h00;
    exp_acc[0] = 4'd8; exp_acc[1] = 4'd15; exp_acc[2] = 4'd15; exp_acc[3] = 4'd15;
    step(1, 0, 2'b00, 8'h00, 8'h00, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 2'b00, jv[i], 8'h00, 0);
      checks++; if (q !== jv[i]) begin fails++; $display("FAIL sat_q[%0d] got %h want %h", i, q, jv[i]); end
      checks++; if (chg_acc !== exp_acc[i]) begin fails++; $display("FAIL sat_acc[%0d] got %0d want %0d", i, chg_acc, exp_acc[i]); end
    end
    step(1, 1, 2'b00, 8'hFF, 8'h00, 0);
    checks++; if (chg_acc !== 4'd0) begin fails++; $display("FAIL sat_rst_acc got %0d want 0", chg_acc); end
    checks++; if (q !== 8'h00) begin fails++; $display("FAIL sat_rst_q got %h want 00", q); end
  endtask

  // One edge per mode, mode changing every cycle.
  task automatic test_back_to_back;
    logic [1:0] mv [4];
    logic [7:0] jv [4];
    logic [7:0] kv [4];
    logic [7:0] exp_q [4];
    logic [3:0] exp_cnt [4];
    logic [3:0] exp_acc [4];
    mv[0] = 2'b00; jv[0] = 8'h3C; kv[0] = 8'h00; exp_q[0] = 8'h3C; exp_cnt[0] = 4'd4; exp_acc[0] = 4'd4;
    mv[1] = 2'b10; jv[1] = 8'hFF; kv[1] = 8'h00; exp_q[1] = 8'hC3; exp_cnt[1] = 4'd8; exp_acc[1] = 4'd12;
    mv[2] = 2'b01; jv[2] = 8'h0F; kv[2] = 8'h00; exp_q[2] = 8'hCF; exp_cnt[2] = 4'd2; exp_acc[2] = 4'd14;
    mv[3] = 2'b11; jv[3] = 8'h00; kv[3] = 8'hC0; exp_q[3] = 8'h0F; exp_cnt[3] = 4'd2; exp_acc[3] = 4'd15;
    step(1, 0, 2'b00, 8'h00, 8'h00, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, mv[i], jv[i], kv[i], 0);
      checks++; if (q !== exp_q[i]) begin fails++; $display("FAIL b2b_q[%0d] got %h want %h", i, q, exp_q[i]); end
      checks++; if (chg_cnt !== exp_cnt[i]) begin fails++; $display("FAIL b2b_cnt[%0d] got %0d want %0d", i, chg_cnt, exp_cnt[i]); end
      checks++; if (chg_acc !== exp_acc[i]) begin fails++; $display("FAIL b2b_acc[%0d] got %0d want %0d", i, chg_acc, exp_acc[i]); end
    end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL b2b_err got %b want 0", err); end
  endtask

  task automatic test_reset_mid;
    step(1, 0, 2'b00, 8'h00, 8'h00, 0);
    step(0, 1, 2'b11, 8'h80, 8'h80, 0);
    step(0, 1, 2'b01, 8'hFF, 8'hFF, 0);
    checks++; if (q !== 8'hFF || err !== 1'b1) begin fails++; $display("FAIL mid_pre got q=%h err=%b want q=FF err=1", q, err); end
    step(1, 1, 2'b01, 8'hFF, 8'hFF, 0);
    checks++; if (q !== 8'h00) begin fails++; $display("FAIL mid_rst_q got %h want 00", q); end
    checks++; if (chg_cnt !== 4'd0) begin fails++; $display("FAIL mid_rst_cnt got %0d want 0", chg_cnt); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL mid_rst_err got %b want 0", err); end
    checks++; if (chg_acc !== 4'd0) begin fails++; $display("FAIL mid_rst_acc got %0d want 0", chg_acc); end
    step(0, 1, 2'b01, 8'hFF, 8'hFF, 0);
    checks++; if (q !== 8'hFF) begin fails++; $display("FAIL mid_resume_q got %h want FF", q); end
    checks++; if (chg_cnt !== 4'd8) begin fails++; $display("FAIL mid_resume_cnt got %0d want 8", chg_cnt); end
    checks++; if (chg_acc !== 4'd8) begin fails++; $display("FAIL mid_resume_acc got %0d want 8", chg_acc); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; j = '0; k = '0; clr_err = 1'b0;
    @(negedge clk);
    test_reset;
    test_d_mode;
    test_jk_mode;
    test_t_mode;
    test_sr_mode;
    test_saturation;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
